apb_timer_periph: RTL and testbench

- APB slave timer peripheral on the MCU's APB bus; it occupies one PSEL slot alongside RAM, GPO, GPI, GPIOA, FND and UART.
- Provides a 16-bit prescaler, a 32-bit up-counter with auto-reload, a sticky update flag and a level interrupt output.
- The CPU configures and polls it through zero-wait-state APB transfers.
- Counting runs on PCLK.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_core.sv | 71 +++++++
 rtl/apb_timer_periph.sv | 127 ++++++++++++
 tb/tb_apb_timer_periph.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the APB timer: register offsets, TCR bit positions,
// reset values.
package timer_pkg;

    // Byte offsets; only bits [4:2] are decoded on the bus.
    localparam logic [4:0] TCR_OFS  = 5'h00;
    localparam logic [4:0] PSC_OFS  = 5'h04;
    localparam logic [4:0] ARR_OFS  = 5'h08;
    localparam logic [4:0] TCNT_OFS = 5'h0C;
    localparam logic [4:0] SR_OFS   = 5'h10;

    // TCR bit positions.
    localparam int EN_BIT  = 0;
    localparam int IE_BIT  = 1;
    localparam int OS_BIT  = 2;
    localparam int CLR_BIT = 3;

    // SR bit positions.
    localparam int UIF_BIT = 0;

    // Auto-reload comes out of reset at full scale.
    localparam logic [31:0] ARR_RST = 32'hFFFF_FFFF;

    // Word index used by the address decoder.
    function automatic logic [2:0] reg_idx(input logic [4:0] ofs);
        return ofs[4:2];
    endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler plus 32-bit up-counter with auto-reload and update generation.
module timer_core
    import timer_pkg::*;
#(
    parameter int PSC_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             oneshot,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] arr,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] tcnt,
    output logic             update_pulse,
    output logic             oneshot_done
);

    localparam logic [PSC_W-1:0] P_ONE = PSC_W'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [PSC_W-1:0] pcnt_d, pcnt_q;
    logic [CNT_W-1:0] tcnt_d, tcnt_q;
    logic             tick;

    // Next-state: clear beats load, load beats the tick's compare/reload.
    // The >= compare keeps a PSC lowered mid-count from overrunning.
    always_comb begin
        tick         = en && (pcnt_q >= psc);
        pcnt_d       = pcnt_q;
        tcnt_d       = tcnt_q;
        update_pulse = 1'b0;
        if (clr) begin
            pcnt_d = '0;
            tcnt_d = '0;
        end else begin
            if (en) begin
                pcnt_d = tick ? '0 : pcnt_q + P_ONE;
            end
            if (load) begin
                tcnt_d = load_val;
            end else if (tick) begin
                if (tcnt_q == arr) begin
                    tcnt_d       = '0;
                    update_pulse = 1'b1;
                end else begin
                    // Above ARR this simply wraps at all-ones with no update.
                    tcnt_d = tcnt_q + C_ONE;
                end
            end
        end
        oneshot_done = update_pulse & oneshot;
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign tcnt = tcnt_q;

endmodule

// File: rtl/apb_timer_periph.sv
// APB slave timer: zero-wait register file, W1C status and irq gating
// around timer_core.
module apb_timer_periph
    import timer_pkg::*;
#(
    parameter int PSC_W = 16,
    parameter int CNT_W = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    logic             en_d, en_q;
    logic             ie_d, ie_q;
    logic             os_d, os_q;
    logic             uif_d, uif_q;
    logic [PSC_W-1:0] psc_d, psc_q;
    logic [CNT_W-1:0] arr_d, arr_q;

    logic             access, wr;
    logic [2:0]       idx;
    logic             wr_tcr, wr_psc, wr_arr, wr_tcnt, wr_sr;
    logic             core_en, core_clr;
    logic [CNT_W-1:0] tcnt;
    logic             update_pulse, oneshot_done;
    logic             unused_addr;

    assign access      = PSEL & PENABLE;
    assign wr          = access & PWRITE;
    assign idx         = PADDR[4:2];
    assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

    assign wr_tcr  = wr && (idx == reg_idx(TCR_OFS));
    assign wr_psc  = wr && (idx == reg_idx(PSC_OFS));
    assign wr_arr  = wr && (idx == reg_idx(ARR_OFS));
    assign wr_tcnt = wr && (idx == reg_idx(TCNT_OFS));
    assign wr_sr   = wr && (idx == reg_idx(SR_OFS));

    // A TCR write that drops EN suppresses any tick on that same edge.
    assign core_en  = en_q & ~(wr_tcr & ~PWDATA[EN_BIT]);
    assign core_clr = wr_tcr & PWDATA[CLR_BIT];

    timer_core #(
        .PSC_W (PSC_W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk          (PCLK),
        .rst_n        (PRESET),
        .en           (core_en),
        .oneshot      (os_q),
        .psc          (psc_q),
        .arr          (arr_q),
        .clr          (core_clr),
        .load         (wr_tcnt),
        .load_val     (PWDATA[CNT_W-1:0]),
        .tcnt         (tcnt),
        .update_pulse (update_pulse),
        .oneshot_done (oneshot_done)
    );

    // Register file next-state; bus writes beat one-shot EN clear, UIF set beats W1C.
    always_comb begin
        en_d  = en_q;
        ie_d  = ie_q;
        os_d  = os_q;
        psc_d = psc_q;
        arr_d = arr_q;
        uif_d = uif_q;
        if (wr_tcr) begin
            en_d = PWDATA[EN_BIT];
            ie_d = PWDATA[IE_BIT];
            os_d = PWDATA[OS_BIT];
        end else if (oneshot_done) begin
            en_d = 1'b0;
        end
        if (wr_psc) psc_d = PWDATA[PSC_W-1:0];
        if (wr_arr) arr_d = PWDATA[CNT_W-1:0];
        if (wr_sr && PWDATA[UIF_BIT]) uif_d = 1'b0;
        if (update_pulse)             uif_d = 1'b1;
    end

    // Register file state.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            os_q  <= 1'b0;
            psc_q <= '0;
            arr_q <= CNT_W'(ARR_RST);
            uif_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            ie_q  <= ie_d;
            os_q  <= os_d;
            psc_q <= psc_d;
            arr_q <= arr_d;
            uif_q <= uif_d;
        end
    end

    // Read mux; quiet outside the access phase, unmapped words read zero.
    always_comb begin
        PRDATA = '0;
        if (access) begin
            case (idx)
                reg_idx(TCR_OFS):  PRDATA = {28'b0, 1'b0, os_q, ie_q, en_q};
                reg_idx(PSC_OFS):  PRDATA = 32'(psc_q);
                reg_idx(ARR_OFS):  PRDATA = 32'(arr_q);
                reg_idx(TCNT_OFS): PRDATA = 32'(tcnt);
                reg_idx(SR_OFS):   PRDATA = {31'b0, uif_q};
                default:           PRDATA = '0;
            endcase
        end
    end

    assign PREADY = access;
    assign irq    = uif_q & ie_q;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Directed bench for apb_timer_periph with hand-computed expectations.
module tb_apb_timer_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    apb_timer_periph dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    localparam logic [31:0] A_TCR  = 32'h00;
    localparam logic [31:0] A_PSC  = 32'h04;
    localparam logic [31:0] A_ARR  = 32'h08;
    localparam logic [31:0] A_TCNT = 32'h0C;
    localparam logic [31:0] A_SR   = 32'h10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Full setup+access write; commits on the posedge, returns 1 ns later.
    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1 bus_idle();
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic rdy);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA; rdy = PREADY;
        @(posedge PCLK);
        #1 bus_idle();
    endtask

    // Hold a read access open and sample once per cycle (reads are side-effect free).
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
    endtask

    logic [31:0] d;
    logic        rdy;
    logic [31:0] exp_seq [0:8] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        PRESET = 1'b0; PADDR = '0; PWDATA = '0;
        bus_idle();
        #1;
        chk("rst_pready", {31'b0, PREADY}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        #11 PRESET = 1'b1;

        // Basic count: PSC=1, ARR=3, EN|IE
        apb_wr(A_PSC, 32'd1);
        apb_wr(A_ARR, 32'd3);
        apb_wr(A_TCR, 32'h3);
        for (int k = 0; k <= 8; k++) begin
            peek(A_TCNT, d);
            chk($sformatf("cnt_seq%0d", k), d, exp_seq[k]);
            if (k == 7) chk("cnt_irq_pre", {31'b0, irq}, 32'd0);
            if (k == 8) chk("cnt_irq_set", {31'b0, irq}, 32'd1);
        end

        // W1C: stop counting, writing 0 keeps UIF, writing 1 clears it
        apb_wr(A_TCR, 32'h2);
        apb_wr(A_SR, 32'h0);
        apb_rd(A_SR, d, rdy);
        chk("w1c_zero_keeps", d, 32'd1);
        chk("w1c_irq_kept", {31'b0, irq}, 32'd1);
        apb_wr(A_SR, 32'h1);
        chk("w1c_irq_clr", {31'b0, irq}, 32'd0);
        apb_rd(A_SR, d, rdy);
        chk("w1c_uif_clr", d, 32'd0);

        // One-shot: PSC=0, ARR=2, EN|OS with CLR to start from zero
        apb_wr(A_PSC, 32'd0);
        apb_wr(A_ARR, 32'd2);
        apb_wr(A_TCR, 32'hD);
        for (int k = 0; k <= 13; k++) begin
            if (k == 3) begin
                peek(A_SR, d);
                chk("os_uif", d, 32'd1);
            end else begin
                peek(A_TCNT, d);
                chk($sformatf("os_tcnt%0d", k), d, (k < 3) ? k : 0);
            end
        end
        apb_rd(A_TCR, d, rdy);
        chk("os_tcr", d, 32'h4);
        apb_wr(A_SR, 32'h1);

        // Collision: W1C on the overflow edge, set wins
        apb_wr(A_ARR, 32'd3);
        apb_wr(A_TCR, 32'h9);
        repeat (2) @(posedge PCLK);
        apb_wr(A_SR, 32'h1);
        apb_rd(A_SR, d, rdy);
        chk("col_w1c_uif", d, 32'd1);

        // Collision: CLR|EN on the overflow edge, clear wins
        apb_wr(A_TCR, 32'h8);
        apb_wr(A_SR, 32'h1);
        apb_wr(A_TCR, 32'h9);
        repeat (2) @(posedge PCLK);
        apb_wr(A_TCR, 32'h9);
        peek(A_TCNT, d);
        chk("col_clr_tcnt", d, 32'd0);
        peek(A_SR, d);
        chk("col_clr_uif", d, 32'd0);
        peek(A_TCNT, d);
        chk("col_clr_run", d, 32'd2);

        // Override: TCNT loaded above ARR wraps silently, then updates at ARR
        apb_wr(A_TCR, 32'h8);
        apb_wr(A_SR, 32'h1);
        apb_wr(A_ARR, 32'd5);
        apb_wr(A_TCR, 32'h1);
        apb_wr(A_TCNT, 32'hFFFF_FFF0);
        for (int k = 0; k <= 22; k++) begin
            if (k == 16 || k == 22) begin
                peek(A_SR, d);
                chk($sformatf("ovr_uif%0d", k), d, (k == 22) ? 32'd1 : 32'd0);
            end else begin
                peek(A_TCNT, d);
                chk($sformatf("ovr_tcnt%0d", k), d,
                    (k < 16) ? (32'hFFFF_FFF0 + 32'(k)) : 32'(k - 16));
            end
        end

        // Asynchronous reset mid-count with irq high
        apb_wr(A_TCR, 32'h3);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_TCNT;
        #1 chk("arst_irq_pre", {31'b0, irq}, 32'd1);
        #1 PRESET = 1'b0;
        #1;
        chk("arst_tcnt", PRDATA, 32'd0);
        chk("arst_irq", {31'b0, irq}, 32'd0);
        @(negedge PCLK);
        bus_idle();
        PRESET = 1'b1;
        apb_rd(A_ARR, d, rdy);
        chk("rst_arr", d, 32'hFFFF_FFFF);
        apb_rd(A_TCR, d, rdy);
        chk("rst_tcr", d, 32'd0);
        apb_rd(A_PSC, d, rdy);
        chk("rst_psc", d, 32'd0);
        apb_rd(A_SR, d, rdy);
        chk("rst_sr", d, 32'd0);
        apb_rd(32'h18, d, rdy);
        chk("unmapped_rd", d, 32'd0);
        chk("unmapped_rdy", {31'b0, rdy}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
